// File: rtl/vga_pkg.sv
// VGA timing constants shared with the sync generator,
// plus the update-scheduler state encoding.
package vga_pkg;

  localparam int VGA_H_ACTIVE   = 640;
  localparam int VGA_H_FP_END   = 656;
  localparam int VGA_H_SYNC_END = 752;
  localparam int VGA_H_TOTAL    = 800;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_TOTAL  = 525;

  localparam int VGA_ADDR_W = 4;
  localparam int VGA_DATA_W = 8;
  localparam int VGA_MAX_WR = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } sched_state_e;

endpackage

// File: rtl/vga_update_scheduler_if.sv
// Requester side and register-file write port of the
// display-register update scheduler.
interface vga_update_scheduler_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);

  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] data0;
  logic              ack0;

  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] data1;
  logic              ack1;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output req0, addr0, data0,
    output req1, addr1, data1,
    input  ack0, ack1,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  req0, addr0, data0,
    input  req1, addr1, data1,
    output ack0, ack1,
    output wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/vga_update_scheduler_rr_arb2.sv
// Two-way round-robin arbiter: ptr selects who wins a tie,
// a sole requester always wins.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o
);

  // Tie goes to the pointed-at requester.
  always_comb begin
    grant_o    = 2'b00;
    grant_o[0] = req_i[0] & (~req_i[1] | ~ptr_i);
    grant_o[1] = req_i[1] & (~req_i[0] |  ptr_i);
  end

endmodule

// File: rtl/vga_update_scheduler.sv
// Grants register-file writes only during vertical blanking,
// round-robin between two requesters, capped per frame.
module vga_update_scheduler
  import vga_pkg::*;
#(
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_TOTAL  = VGA_V_TOTAL,
  parameter int ADDR_W   = VGA_ADDR_W,
  parameter int DATA_W   = VGA_DATA_W,
  parameter int MAX_WR   = VGA_MAX_WR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pix_y_i,
  vga_update_scheduler_if.slave bus,
  output logic       win_open_o,
  output logic       frame_done_o
);

  localparam int CNT_W = $clog2(MAX_WR + 1);

  localparam logic [9:0] WIN_LO = 10'(V_ACTIVE);
  localparam logic [9:0] WIN_HI = 10'(V_TOTAL - 2);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(MAX_WR);

  sched_state_e state_q, state_d;

  logic win;
  logic win_rise;
  logic win_fall;
  logic win_open_q;
  logic frame_done_q;

  logic rr_ptr_q, rr_ptr_d;

  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] cnt_eff;

  logic       can_grant;
  logic       granted;
  logic [1:0] arb_req;
  logic [1:0] grant;

  logic wr_en_q, wr_en_d;
  logic ack0_q, ack0_d;
  logic ack1_q, ack1_d;

  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  // The last line is a guard: a grant made on it would
  // land in visible line 0.
  assign win = (pix_y_i >= WIN_LO) &&
               (pix_y_i <= WIN_HI);

  assign win_rise = win & ~win_open_q;
  assign win_fall = ~win & win_open_q;

  // A window opening restarts the budget in the same
  // cycle, so a saturated count cannot block its first grant.
  assign cnt_eff = win_rise ? '0 : wr_cnt_q;

  assign can_grant = (state_q == ST_IDLE) && win &&
                     (cnt_eff < CNT_MAX);

  assign arb_req = can_grant ?
                   {bus.req1, bus.req0} : 2'b00;

  rr_arb2 u_arb (
    .req_i   (arb_req),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant)
  );

  assign granted = |grant;

  // Next state and the registered write/ack values.
  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (granted) begin
          state_d = ST_HOLD;
          wr_en_d = 1'b1;
          ack0_d  = grant[0];
          ack1_d  = grant[1];
          unique case (1'b1)
            grant[0]: begin
              wr_addr_d = bus.addr0;
              wr_data_d = bus.data0;
            end
            grant[1]: begin
              wr_addr_d = bus.addr1;
              wr_data_d = bus.data1;
            end
          endcase
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Loser of a grant gets priority next time.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant[0]) begin
      rr_ptr_d = 1'b1;
    end else if (grant[1]) begin
      rr_ptr_d = 1'b0;
    end
  end

  // Per-window grant count, cleared on window open.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (win_rise) begin
      wr_cnt_d = granted ? CNT_W'(1) : '0;
    end else if (granted && wr_cnt_q != CNT_MAX) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end
  end

  // State, arbitration and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= 1'b0;
      wr_cnt_q     <= '0;
      win_open_q   <= 1'b0;
      frame_done_q <= 1'b0;
      wr_en_q      <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      wr_cnt_q     <= wr_cnt_d;
      win_open_q   <= win;
      frame_done_q <= win_fall;
      wr_en_q      <= wr_en_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.ack0    = ack0_q;
  assign bus.ack1    = ack1_q;

  assign win_open_o   = win_open_q;
  assign frame_done_o = frame_done_q;

endmodule
